// File: rtl/mem_bus_pkg.sv
// Shared types and command-word field offsets for the DDR4 mem-bus arbiter.
package mem_bus_pkg;

  localparam int unsigned CMD_W    = 19;
  localparam int unsigned CS_N_BIT = 18;
  localparam int unsigned ACT_BIT  = 17;
  localparam int unsigned BG_LSB   = 12;
  localparam int unsigned BA_BIT   = 11;

  // Idle bus word: only cs_N set, so the DIMM ignores the bus.
  localparam logic [CMD_W-1:0] IDLE_CMD = CMD_W'(1) << CS_N_BIT;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT0  = 2'd1,
    ST_GRANT1  = 2'd2,
    ST_REFRESH = 2'd3
  } arb_state_t;

  // Field view of the command word for users that decode it.
  typedef struct packed {
    logic        cs_n;
    logic        act;
    logic [16:0] addr;
  } mem_cmd_t;

endpackage

// File: rtl/mem_bus_arbiter_refresh_timer.sv
// Free-running refresh period counter plus the refresh hold-off countdown.
module refresh_timer #(
  parameter int unsigned REFRESH_CYCLE   = 5120,
  parameter int unsigned REFRESH_LATENCY = 16,
  parameter int unsigned GUARD_CYCLES    = 64
) (
  input  logic clk_in,
  input  logic rst_N_in,
  input  logic lat_start,
  output logic ref_wrap,
  output logic ref_pending,
  output logic lat_done
);

  localparam int unsigned RC_W  = (REFRESH_CYCLE > 1) ? $clog2(REFRESH_CYCLE) : 1;
  localparam int unsigned LAT_W = (REFRESH_LATENCY > 1) ? $clog2(REFRESH_LATENCY) : 1;

  logic [RC_W-1:0]  ref_cnt_q;
  logic [LAT_W-1:0] lat_cnt_q;

  assign ref_wrap    = (ref_cnt_q == RC_W'(REFRESH_CYCLE - 1));
  assign ref_pending = (ref_cnt_q >= RC_W'(REFRESH_CYCLE - GUARD_CYCLES));
  assign lat_done    = (lat_cnt_q == '0);

  // Refresh period counter, runs regardless of arbiter state.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      ref_cnt_q <= '0;
    end else if (ref_wrap) begin
      ref_cnt_q <= '0;
    end else begin
      ref_cnt_q <= ref_cnt_q + RC_W'(1);
    end
  end

  // Loaded on REFRESH entry so the state lasts exactly REFRESH_LATENCY cycles.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      lat_cnt_q <= '0;
    end else if (lat_start) begin
      lat_cnt_q <= LAT_W'(REFRESH_LATENCY - 1);
    end else if (lat_cnt_q != '0) begin
      lat_cnt_q <= lat_cnt_q - LAT_W'(1);
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin burst arbiter for the shared DDR4 command/address bus with
// refresh-window protection.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned PADDR_BITS      = 19,
  parameter int unsigned REFRESH_CYCLE   = 5120,
  parameter int unsigned REFRESH_LATENCY = 16,
  parameter int unsigned GUARD_CYCLES    = 64,
  parameter int unsigned MAX_BURST       = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  req0_valid_in,
  input  logic [PADDR_BITS-1:0] req0_addr_in,
  input  logic                  req0_last_in,
  output logic                  req0_ready_out,
  input  logic                  req1_valid_in,
  input  logic [PADDR_BITS-1:0] req1_addr_in,
  input  logic                  req1_last_in,
  output logic                  req1_ready_out,
  input  logic                  mem_bus_ready_in,
  output logic                  mem_bus_valid_out,
  output logic [PADDR_BITS-1:0] mem_bus_addr_out,
  output logic [1:0]            grant_out,
  output logic                  refresh_active_out,
  output logic                  refresh_late_out,
  output logic                  burst_error_out
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);
  // cs_N is the MSB of the command word; everything else low.
  localparam logic [PADDR_BITS-1:0] IDLE_WORD = PADDR_BITS'(1) << (PADDR_BITS - 1);

  arb_state_t        state_q, state_d;
  logic              rr_ptr_q;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic              refresh_due_q;
  logic              ref_wrap, ref_pending, lat_done, lat_start;
  logic              in_grant, cur_valid, cur_last, burst_hs, burst_end;

  refresh_timer #(
    .REFRESH_CYCLE   (REFRESH_CYCLE),
    .REFRESH_LATENCY (REFRESH_LATENCY),
    .GUARD_CYCLES    (GUARD_CYCLES)
  ) u_refresh_timer (
    .clk_in      (clk_in),
    .rst_N_in    (rst_N_in),
    .lat_start   (lat_start),
    .ref_wrap    (ref_wrap),
    .ref_pending (ref_pending),
    .lat_done    (lat_done)
  );

  // Current owner's valid/last, zero when nobody owns the bus.
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        cur_valid = req0_valid_in;
        cur_last  = req0_last_in;
      end
      ST_GRANT1: begin
        cur_valid = req1_valid_in;
        cur_last  = req1_last_in;
      end
      default: ;
    endcase
  end

  assign in_grant  = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);
  assign burst_hs  = cur_valid && mem_bus_ready_in;
  assign burst_end = burst_hs && cur_last;

  // State register.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: refresh beats arbitration; bursts are never cut short.
  always_comb begin
    state_d   = state_q;
    lat_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_wrap) begin
          state_d = ST_REFRESH;
        end else if (!ref_pending) begin
          if (req0_valid_in && req1_valid_in) begin
            state_d = rr_ptr_q ? ST_GRANT1 : ST_GRANT0;
          end else if (req0_valid_in) begin
            state_d = ST_GRANT0;
          end else if (req1_valid_in) begin
            state_d = ST_GRANT1;
          end
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (burst_end) begin
          state_d = (refresh_due_q || ref_wrap) ? ST_REFRESH : ST_IDLE;
        end
      end
      ST_REFRESH: begin
        if (lat_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    lat_start = (state_d == ST_REFRESH) && (state_q != ST_REFRESH);
  end

  // Burst accounting, round-robin pointer and sticky status flags.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      rr_ptr_q         <= 1'b0;
      beat_cnt_q       <= '0;
      refresh_due_q    <= 1'b0;
      refresh_late_out <= 1'b0;
      burst_error_out  <= 1'b0;
    end else begin
      if (burst_hs) begin
        if (beat_cnt_q >= BEAT_W'(MAX_BURST)) begin
          burst_error_out <= 1'b1;
        end
        if (cur_last) begin
          beat_cnt_q <= '0;
          rr_ptr_q   <= (state_q == ST_GRANT0);
        end else if (beat_cnt_q != BEAT_W'(MAX_BURST)) begin
          beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
        end
      end
      if (in_grant && ref_wrap) begin
        refresh_due_q    <= 1'b1;
        refresh_late_out <= 1'b1;
      end else if ((state_q == ST_REFRESH) && lat_done) begin
        refresh_due_q <= 1'b0;
      end
    end
  end

  // Output decode: bus mux and readies follow the owner combinationally.
  always_comb begin
    mem_bus_addr_out   = IDLE_WORD;
    mem_bus_valid_out  = 1'b0;
    req0_ready_out     = 1'b0;
    req1_ready_out     = 1'b0;
    grant_out          = 2'b00;
    refresh_active_out = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        mem_bus_addr_out  = req0_addr_in;
        mem_bus_valid_out = req0_valid_in;
        req0_ready_out    = mem_bus_ready_in;
        grant_out         = 2'b01;
      end
      ST_GRANT1: begin
        mem_bus_addr_out  = req1_addr_in;
        mem_bus_valid_out = req1_valid_in;
        req1_ready_out    = mem_bus_ready_in;
        grant_out         = 2'b10;
      end
      ST_REFRESH: refresh_active_out = 1'b1;
      default: ;
    endcase
  end

endmodule
